// File: rtl/dram_io_bridge_pkg.sv
// Shared decode constants and display helpers for the data-side bridge.
package dram_io_bridge_pkg;

  localparam logic [1:0] IO_PAGE   = 2'b11;
  localparam logic [1:0] OFF_SW    = 2'd0;
  localparam logic [1:0] OFF_LED   = 2'd1;
  localparam logic [1:0] OFF_DISP  = 2'd2;
  localparam logic [1:0] OFF_CYC   = 2'd3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low one-hot digit enable for scan index idx.
  function automatic logic [7:0] digit_enable(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/dram_io_bridge_hex_to_seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/dram_io_bridge.sv
// Core data-port responder: distributed data RAM plus a memory-mapped I/O page
// (switches, LEDs, 8-digit seven-segment display, cycle counter).
module dram_io_bridge
  import dram_io_bridge_pkg::*;
#(
  parameter int DRAM_AW  = 12,
  parameter int SCAN_DIV = 50000,
  parameter int SW_W     = 24,
  parameter int LED_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [13:0]       x_addr,
  input  logic              x_dram_wen,
  input  logic [31:0]       x_dram_wdata,
  output logic [31:0]       dram_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        seg_an,
  output logic [7:0]        seg_ca
);

  localparam int            PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);

  logic [31:0] ram_q [0:(1<<DRAM_AW)-1];

  logic             is_io;
  logic [1:0]       io_off;
  logic             ram_we;
  logic             io_we;

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_an_q, seg_an_d;
  logic [7:0]       seg_ca_q, seg_ca_d;
  logic [3:0]       nib;
  logic [6:0]       seg7;

  assign is_io  = (x_addr[13:12] == IO_PAGE);
  assign io_off = x_addr[1:0];
  assign ram_we = x_dram_wen && !is_io;
  assign io_we  = x_dram_wen && is_io;

  always_comb begin
    led_d  = led_q;
    disp_d = disp_q;
    cyc_d  = cyc_q + 32'd1;
    pre_d  = pre_q + 1'b1;
    idx_d  = idx_q;
    if (io_we) begin
      case (io_off)
        OFF_LED:  led_d  = x_dram_wdata[LED_W-1:0];
        OFF_DISP: disp_d = x_dram_wdata;
        OFF_CYC:  cyc_d  = '0;
        default:  ;
      endcase
    end
    if (pre_q == PRE_TC) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Segment registers are loaded from next-state index and value, so they
  // always match the registered index on the same edge.
  assign nib      = disp_d[{idx_d, 2'b00} +: 4];
  assign seg_an_d = digit_enable(idx_d);
  assign seg_ca_d = {SEG_BLANK[7], seg7};

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (seg7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      led_q    <= '0;
      disp_q   <= '0;
      cyc_q    <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_an_q <= 8'hFE;
      seg_ca_q <= 8'hC0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      led_q    <= led_d;
      disp_q   <= disp_d;
      cyc_q    <= cyc_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_an_q <= seg_an_d;
      seg_ca_q <= seg_ca_d;
    end
  end

  // RAM contents are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[x_addr[DRAM_AW-1:0]] <= x_dram_wdata;
    end
  end

  always_comb begin
    dram_rdata = ram_q[x_addr[DRAM_AW-1:0]];
    if (is_io) begin
      case (io_off)
        OFF_SW:   dram_rdata = 32'(sw_s2_q);
        OFF_LED:  dram_rdata = 32'(led_q);
        OFF_DISP: dram_rdata = disp_q;
        OFF_CYC:  dram_rdata = cyc_q;
        default:  ;
      endcase
    end
  end

  assign led    = led_q;
  assign seg_an = seg_an_q;
  assign seg_ca = seg_ca_q;

endmodule

// File: tb/tb_dram_io_bridge.sv
// Directed bench for dram_io_bridge: read scoreboard plus a display-scan model.
module tb_dram_io_bridge;

  localparam int DRAM_AW  = 12;
  localparam int SCAN_DIV = 4;
  localparam int SW_W     = 24;
  localparam int LED_W    = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [13:0]      x_addr;
  logic             x_dram_wen;
  logic [31:0]      x_dram_wdata;
  logic [31:0]      dram_rdata;
  logic [SW_W-1:0]  sw;
  logic [LED_W-1:0] led;
  logic [7:0]       seg_an;
  logic [7:0]       seg_ca;

  always #5 clk = ~clk;

  dram_io_bridge #(
    .DRAM_AW  (DRAM_AW),
    .SCAN_DIV (SCAN_DIV),
    .SW_W     (SW_W),
    .LED_W    (LED_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .x_addr       (x_addr),
    .x_dram_wen   (x_dram_wen),
    .x_dram_wdata (x_dram_wdata),
    .dram_rdata   (dram_rdata),
    .sw           (sw),
    .led          (led),
    .seg_an       (seg_an),
    .seg_ca       (seg_ca)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  int          m_pre;
  int          m_idx;
  logic [31:0] m_disp;
  bit          settled;

  function automatic logic [7:0] pat(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the scan model with the inputs seen at the edge,
  // then check the display outputs against it.
  task automatic tick();
    bit         stepped;
    logic [7:0] exp_an;
    @(posedge clk);
    stepped = 1'b0;
    if (rst) begin
      m_pre   = 0;
      m_idx   = 0;
      m_disp  = '0;
      settled = 1'b1;
    end else begin
      if (m_pre == SCAN_DIV - 1) begin
        m_pre   = 0;
        m_idx   = (m_idx + 1) % 8;
        stepped = 1'b1;
      end else begin
        m_pre++;
      end
      if (x_dram_wen && x_addr[13:12] == 2'b11 && x_addr[1:0] == 2'd2) begin
        m_disp  = x_dram_wdata;
        settled = 1'b0;
      end else if (stepped) begin
        settled = 1'b1;
      end
    end
    #1;
    exp_an = ~(8'h01 << m_idx);
    chk($sformatf("seg_an idx%0d", m_idx), 32'(seg_an), 32'(exp_an));
    if (settled)
      chk($sformatf("seg_ca idx%0d", m_idx), 32'(seg_ca), 32'(pat(m_disp[4*m_idx +: 4])));
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string tag);
    x_addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    chk(tag_q.pop_front(), dram_rdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    x_addr       = a;
    x_dram_wdata = d;
    x_dram_wen   = 1'b1;
    tick();
    x_dram_wen   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    x_addr       = '0;
    x_dram_wen   = 1'b0;
    x_dram_wdata = '0;
    sw           = '0;
    m_pre        = 0;
    m_idx        = 0;
    m_disp       = '0;
    settled      = 1'b1;

    tick();
    tick();
    rst = 1'b0;
    chk("led_reset", 32'(led), 32'h0);
    chk("seg_ca_reset", 32'(seg_ca), 32'hC0);
    rd(14'h3003, 32'd0, "cyc_reset");
    rd(14'h3002, 32'd0, "disp_reset");
    rd(14'h3000, 32'd0, "sw_reset");
    rd(14'h3001, 32'd0, "led_rd_reset");

    repeat (10) tick();
    rd(14'h3003, 32'd10, "cyc_10");

    x_dram_wen   = 1'b1;
    x_dram_wdata = 32'h1234_5678;
    rd(14'h3003, 32'd10, "cyc_pre_edge_on_write");
    tick();
    x_dram_wen = 1'b0;
    rd(14'h3003, 32'd0, "cyc_cleared");
    tick();
    rd(14'h3003, 32'd1, "cyc_after_clear");

    wr(14'h0001, 32'h1111_1111);
    wr(14'h0005, 32'hDEAD_BEEF);
    rd(14'h0005, 32'hDEAD_BEEF, "ram_5");
    rd(14'h1005, 32'hDEAD_BEEF, "ram_alias_1005");

    x_dram_wen   = 1'b1;
    x_dram_wdata = 32'h0BAD_F00D;
    rd(14'h0005, 32'hDEAD_BEEF, "ram_rdw_old");
    tick();
    x_dram_wen = 1'b0;
    rd(14'h0005, 32'h0BAD_F00D, "ram_rdw_new");

    wr(14'h3005, 32'h00C0_FFEE);
    chk("led_page_alias", 32'(led), 32'h00C0_FFEE);
    rd(14'h0005, 32'h0BAD_F00D, "ram5_not_written_by_io");

    wr(14'h3001, 32'h00AB_CDEF);
    chk("led_abcdef", 32'(led), 32'h00AB_CDEF);
    rd(14'h0001, 32'h1111_1111, "ram1_unchanged");
    rd(14'h3001, 32'h00AB_CDEF, "led_rd");
    rd(14'h3FF5, 32'h00AB_CDEF, "led_rd_alias");
    rd(14'h2001, 32'h1111_1111, "ram_2001_not_io");

    wr(14'h3001, 32'hFF12_3456);
    rd(14'h3001, 32'h0012_3456, "led_upper_zero");

    wr(14'h3000, 32'hFFFF_FFFF);
    rd(14'h3000, 32'h0, "sw_write_ignored");

    sw = 24'h123456;
    rd(14'h3000, 32'h0, "sw_edge0");
    tick();
    rd(14'h3000, 32'h0, "sw_edge1");
    tick();
    rd(14'h3000, 32'h0012_3456, "sw_edge2");
    tick();
    rd(14'h3000, 32'h0012_3456, "sw_edge3");

    wr(14'h3002, 32'h89AB_CDEF);
    rd(14'h3002, 32'h89AB_CDEF, "disp_rd");
    repeat (40) tick();

    wr(14'h3001, 32'h0000_00FF);
    for (int i = 0; i < 40 && m_idx != 5; i++) tick();
    chk("idx5_reached", 32'(seg_an), 32'hDF);
    chk("led_ff", 32'(led), 32'hFF);

    rst          = 1'b1;
    x_addr       = 14'h3001;
    x_dram_wdata = 32'h0000_00AA;
    x_dram_wen   = 1'b1;
    tick();
    chk("led_rst_wins", 32'(led), 32'h0);
    chk("seg_ca_after_rst", 32'(seg_ca), 32'hC0);
    x_addr       = 14'h0007;
    x_dram_wdata = 32'h7777_7777;
    tick();
    x_dram_wen = 1'b0;
    rst        = 1'b0;
    rd(14'h3003, 32'd0, "cyc_after_rst");
    rd(14'h0005, 32'h0BAD_F00D, "ram_preserved");
    rd(14'h0007, 32'h7777_7777, "ram_write_in_rst");
    rd(14'h3002, 32'h0, "disp_after_rst");
    rd(14'h3001, 32'h0, "led_rd_after_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
